cmp_seq_ctrl: RTL and testbench
===============================

# cmp_seq_ctrl

Sequential magnitude-comparison controller. It compares two WIDTH-bit operands by running a single shared 4-bit compare slice over the operand nibbles, MSB nibble first. It exposes a start/busy/done handshake and registered equal/greater/less flags. It sits above the 4-bit comparator datapath and lets wide or signed operands reuse one nibble comparator instead of a full-width parallel compare.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, minimum 4; NIB = WIDTH/4 nibbles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a compare; sampled only when busy=0.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- a  in  WIDTH  operand A; latched on an accepted start.
- b  in  WIDTH  operand B; latched on an accepted start.
- busy  out  1  compare in progress.
- done  out  1  one-cycle pulse; e/g/l valid from this cycle onward.
- e  out  1  registered A == B.
- g  out  1  registered A > B.
- l  out  1  registered A < B.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE: busy=0, done=0.
  - If start=1, latch a, b and sgn, set nibble index idx=NIB-1, and go to SCAN.
- SCAN: busy=1. Each cycle, compare nibble idx of the latched A and B with the 4-bit slice.
  - Signed mode: bit WIDTH-1 of both operands is inverted before the compare (offset-binary). This applies to the MSB nibble only.
  - The first nibble that differs decides the result: g=1 if the A nibble is larger, l=1 if it is smaller. A per-operation "decided" flag blocks later nibbles from changing the result.
  - If all nibbles are equal, the result is e=1.
  - Exit to DONE on the first differing nibble (see Configuration) or after idx=0. Otherwise decrement idx.
- DONE: busy=0, done=1 for exactly one cycle, then go to IDLE.
  - A start sampled in DONE is accepted (back-to-back) and goes directly to SCAN.
- Result flags:
  - e/g/l update only on the transition into DONE.
  - They are exactly one-hot after the first completed compare.
  - They hold until the next completed compare.
- start while busy=1 is ignored. The operand registers do not change.
- The index counter is clog2(NIB) bits wide and never wraps, because exit happens at idx=0.

## Timing
- Reset values (rst_n=0 at a clock edge): busy=0, done=0, e=0, g=0, l=0, state IDLE, idx=0.
- Reset mid-SCAN aborts the compare. Outputs take reset values after that edge and no done pulse is produced.
- Start sampled at edge T sets busy=1 after T.
- After k scan cycles, done=1 during the cycle following edge T+k.
  - k = NIB when the operands are equal, or always when early exit is disabled.
  - Otherwise k = position (1-based from the MSB nibble) of the first differing nibble.
- Throughput: one compare per k+1 cycles when start is held high.
- Simultaneous rst_n=0 and start=1: reset wins.

## Configuration
- CMP_EARLY_EXIT_EN defined: SCAN exits to DONE in the cycle the first differing nibble is found, so latency is data-dependent (1..NIB).
- CMP_EARLY_EXIT_EN undefined: SCAN always runs all NIB nibbles, giving constant latency NIB. The decided flag preserves the first-difference result.
- Flag values are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, e=g=l=0, and no compare starts.
- Equal operands: WIDTH=16, a=16'h1234, b=16'h1234, sgn=0 -> done 4 cycles after the start edge, e=1, g=0, l=0 in both builds.
- MSB nibble difference: a=16'h8000, b=16'h7FFF.
  - sgn=0 -> g=1; done after 1 cycle with CMP_EARLY_EXIT_EN, after 4 cycles without it.
  - sgn=1 -> l=1.
- LSB nibble difference: a=16'h00A5, b=16'h00A6, sgn=0 -> l=1, done after 4 cycles in both builds.
- Handshake:
  - Start a=16'h0001, b=16'h0000; while busy, apply start with a=16'h0000, b=16'hFFFF -> the second request is ignored and the result is g=1.
  - Start asserted in the done cycle with a=b=16'hFFFF -> accepted, next result e=1.
- Reset mid-operation: a=16'h1111, b=16'h1112 started; rst_n=0 on the second SCAN cycle -> busy=0, e=g=l=0 on the next cycle, and no done pulse.

Source files
------------

// File: rtl/cmp_seq_if.sv
// ============================================================================
// Module      : cmp_seq_if
// Description : Start/busy/done handshake and result bundle for cmp_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmp_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             e;
  logic             g;
  logic             l;

  modport master (
    output start, sgn, a, b,
    input  busy, done, e, g, l
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, e, g, l
  );
endinterface

`default_nettype wire

// File: rtl/cmp_seq_ctrl.sv
// ============================================================================
// Module      : cmp_seq_ctrl
// Description : Sequential WIDTH-bit magnitude compare, one 4-bit slice per
//               cycle, MSB nibble first. Define CMP_EARLY_EXIT_EN to leave the
//               scan on the first differing nibble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  cmp_seq_if.slave   bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NIB - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("cmp_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             decided_q, decided_d;
  logic             pg_q, pg_d;
  logic             pl_q, pl_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic             l_q, l_d;

  logic [WIDTH-1:0] w_a_sh, w_b_sh;
  logic [3:0]       w_a_nib, w_b_nib;
  logic             w_nib_gt, w_nib_lt;
  logic             w_res_g, w_res_l;
  logic             w_exit;
  logic             w_accept;

  // Signed operands are stored in offset-binary, so the slice is always unsigned
  // and only the MSB nibble is affected by the sign flip.
  assign w_a_sh  = a_q >> {idx_q, 2'b00};
  assign w_b_sh  = b_q >> {idx_q, 2'b00};
  assign w_a_nib = w_a_sh[3:0];
  assign w_b_nib = w_b_sh[3:0];

  assign w_nib_gt = (w_a_nib > w_b_nib);
  assign w_nib_lt = (w_a_nib < w_b_nib);

  assign w_res_g = decided_q ? pg_q : w_nib_gt;
  assign w_res_l = decided_q ? pl_q : w_nib_lt;

`ifdef CMP_EARLY_EXIT_EN
  assign w_exit = (idx_q == '0) || w_res_g || w_res_l;
`else
  assign w_exit = (idx_q == '0);
`endif

  assign w_accept = bus.start && (state_q != ST_SCAN);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    decided_d = decided_q;
    pg_d      = pg_q;
    pl_d      = pl_q;
    e_d       = e_q;
    g_d       = g_q;
    l_d       = l_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_SCAN: begin
        if (w_exit) begin
          state_d = ST_DONE;
          e_d     = ~(w_res_g | w_res_l);
          g_d     = w_res_g;
          l_d     = w_res_l;
        end else begin
          idx_d     = idx_q - 1'b1;
          decided_d = decided_q | w_nib_gt | w_nib_lt;
          pg_d      = w_res_g;
          pl_d      = w_res_l;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Start is honoured from both IDLE and DONE, giving back-to-back compares.
    if (w_accept) begin
      state_d   = ST_SCAN;
      idx_d     = IDX_TOP;
      a_d       = bus.a ^ (bus.sgn ? SIGN_MASK : '0);
      b_d       = bus.b ^ (bus.sgn ? SIGN_MASK : '0);
      decided_d = 1'b0;
      pg_d      = 1'b0;
      pl_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      pg_q      <= 1'b0;
      pl_q      <= 1'b0;
      e_q       <= 1'b0;
      g_q       <= 1'b0;
      l_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      decided_q <= decided_d;
      pg_q      <= pg_d;
      pl_q      <= pl_d;
      e_q       <= e_d;
      g_q       <= g_d;
      l_q       <= l_d;
    end
  end

  assign bus.busy = (state_q == ST_SCAN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.e    = e_q;
  assign bus.g    = g_q;
  assign bus.l    = l_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_seq_ctrl.sv
// ============================================================================
// Module      : tb_cmp_seq_ctrl
// Description : Directed self-checking bench for cmp_seq_ctrl (WIDTH=16);
//               expected latencies follow CMP_EARLY_EXIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_seq_ctrl;

  localparam int WIDTH = 16;
`ifdef CMP_EARLY_EXIT_EN
  localparam int MSB_LAT = 1;
`else
  localparam int MSB_LAT = 4;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cmp_seq_if #(.WIDTH(WIDTH)) bus ();

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be sampled on one edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.a     = a;
    bus.b     = b;
    bus.sgn   = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; -1 if it never appears.
  task automatic wait_done(input int already, output int lat);
    int n;
    n = already;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    lat = (bus.done === 1'b1) ? n : -1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0000;
    bus.sgn   = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.e, bus.g, bus.l} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy,done,e,g,l=%b expected 00000",
               {bus.busy, bus.done, bus.e, bus.g, bus.l});
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_equal();
    int lat;
    do_start(16'h1234, 16'h1234, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL equal_busy: got %b expected 1", bus.busy);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL equal_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if ({bus.e, bus.g, bus.l} !== 3'b100) begin
      n_fail++;
      $display("FAIL equal_flags: got egl=%b expected 100", {bus.e, bus.g, bus.l});
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || {bus.e, bus.g, bus.l} !== 3'b100) begin
      n_fail++;
      $display("FAIL equal_pulse_hold: got done=%b egl=%b expected done=0 egl=100",
               bus.done, {bus.e, bus.g, bus.l});
    end
  endtask

  task automatic test_msb_diff();
    int lat;
    do_start(16'h8000, 16'h7FFF, 1'b0);
    wait_done(0, lat);
    n_checks++;
    if (lat !== MSB_LAT) begin
      n_fail++;
      $display("FAIL msb_unsigned_latency: got %0d expected %0d", lat, MSB_LAT);
    end
    n_checks++;
    if ({bus.e, bus.g, bus.l} !== 3'b010) begin
      n_fail++;
      $display("FAIL msb_unsigned_flags: got egl=%b expected 010", {bus.e, bus.g, bus.l});
    end
    tick();
    do_start(16'h8000, 16'h7FFF, 1'b1);
    wait_done(0, lat);
    n_checks++;
    if (lat !== MSB_LAT) begin
      n_fail++;
      $display("FAIL msb_signed_latency: got %0d expected %0d", lat, MSB_LAT);
    end
    n_checks++;
    if ({bus.e, bus.g, bus.l} !== 3'b001) begin
      n_fail++;
      $display("FAIL msb_signed_flags: got egl=%b expected 001", {bus.e, bus.g, bus.l});
    end
    tick();
  endtask

  task automatic test_lsb_diff();
    int lat;
    do_start(16'h00A5, 16'h00A6, 1'b0);
    wait_done(0, lat);
    n_checks++;
    if (lat !== 4 || {bus.e, bus.g, bus.l} !== 3'b001) begin
      n_fail++;
      $display("FAIL lsb_unsigned: got lat=%0d egl=%b expected lat=4 egl=001",
               lat, {bus.e, bus.g, bus.l});
    end
    tick();
    // -1 vs -2 signed: differs only in the LSB nibble
    do_start(16'hFFFF, 16'hFFFE, 1'b1);
    wait_done(0, lat);
    n_checks++;
    if (lat !== 4 || {bus.e, bus.g, bus.l} !== 3'b010) begin
      n_fail++;
      $display("FAIL lsb_signed: got lat=%0d egl=%b expected lat=4 egl=010",
               lat, {bus.e, bus.g, bus.l});
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    do_start(16'h0001, 16'h0000, 1'b0);
    bus.a     = 16'h0000;
    bus.b     = 16'hFFFF;
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    wait_done(2, lat);
    n_checks++;
    if (lat !== 4 || {bus.e, bus.g, bus.l} !== 3'b010) begin
      n_fail++;
      $display("FAIL busy_ignore: got lat=%0d egl=%b expected lat=4 egl=010",
               lat, {bus.e, bus.g, bus.l});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_start(16'h0001, 16'h0002, 1'b0);
    wait_done(0, lat);
    n_checks++;
    if (lat !== 4 || {bus.e, bus.g, bus.l} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d egl=%b expected lat=4 egl=001",
               lat, {bus.e, bus.g, bus.l});
    end
    do_start(16'hFFFF, 16'hFFFF, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat !== 4 || {bus.e, bus.g, bus.l} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d egl=%b expected lat=4 egl=100",
               lat, {bus.e, bus.g, bus.l});
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    do_start(16'h1111, 16'h1112, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.e, bus.g, bus.l} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy,done,e,g,l=%b expected 00000",
               {bus.busy, bus.done, bus.e, bus.g, bus.l});
    end
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got activity=%b expected 0", saw_done);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_equal();
    test_msb_diff();
    test_lsb_diff();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
